fl_checkpoint_buf: RTL and testbench
====================================

# fl_checkpoint_buf

Branch checkpoint buffer for the free list's rollback port. At dispatch it records the free-list tail index that follows each dispatched branch and returns a branch tag. On branch resolution it either frees the checkpoint (correct prediction) or drives `rollback_en` / `FL_rollback_idx` to the free list (mispredict). A mispredict squashes the resolving checkpoint and every younger one. The block sits between the decoder/dispatch stage, the branch unit and the free list.

## Interface
- `NUM_CKPT`, 4: checkpoint entries; power of two, at least 2.
- `FL_IDX_W`, 5: free-list index width ($clog2(`NUM_FL)).
- `TAG_W`, $clog2(NUM_CKPT): branch tag width.
- `clock` input 1: system clock.
- `reset` input 1: synchronous, active-high.
- `dispatch_en` input 1: dispatch group accepted this cycle.
- `br_dispatch` input [1:0]: slot i of the dispatch group is a branch.
- `FL_idx` input [1:0][FL_IDX_W-1:0]: free-list tail after slot i's allocation (from the free list).
- `br_resolve_en` input 1: the branch unit resolves a branch this cycle.
- `br_resolve_tag` input TAG_W: tag of the resolving branch.
- `br_mispredict` input 1: the resolving branch was mispredicted.
- `ckpt_ready` output 1: enough free entries for every branch in `br_dispatch`.
- `br_tag` output [1:0][TAG_W-1:0]: tag assigned to slot i.
- `rollback_en` output 1: drive the free-list rollback.
- `FL_rollback_idx` output FL_IDX_W: tail value to restore.
- `ckpt_count` output TAG_W+1: number of live checkpoints.

## Operation
- State:
  - circular array of `NUM_CKPT` entries `{valid, resolved, fl_idx}`;
  - `head` (oldest) and `tail` (next free), each TAG_W wide, wrapping modulo NUM_CKPT;
  - `count` register, 0..NUM_CKPT.
- Allocation:
  - `nbr` = popcount(`br_dispatch`).
  - `ckpt_ready` = (NUM_CKPT − count) ≥ nbr. It is 1 when nbr = 0.
  - When `dispatch_en && ckpt_ready && !mispredict_fire`, each set slot allocates in slot order:
    - slot 0 takes `tail`;
    - slot 1 takes `tail + br_dispatch[0]`.
  - Each allocated entry is written with `fl_idx = FL_idx[i]`, valid=1, resolved=0.
  - `tail` advances by nbr.
  - `br_tag` is always driven with these values, whether or not allocation occurs.
  - With `dispatch_en` and `!ckpt_ready`, nothing is allocated.
- Correct resolve (`br_resolve_en && !br_mispredict`, entry valid):
  - set `resolved` on the entry.
  - A resolve aimed at an invalid entry is ignored.
- Retire: each cycle, if entry[head] is valid and resolved and no mispredict fires, clear it and advance `head` by 1.
  - The check uses registered state, so an entry resolved this cycle retires no earlier than the next cycle.
  - Maximum one retire per cycle.
- Mispredict (`mispredict_fire` = `br_resolve_en && br_mispredict && entry[tag].valid`):
  - `rollback_en` = 1 and `FL_rollback_idx` = entry[tag].fl_idx, both combinational in the same cycle.
  - At the edge, invalidate the tag entry and all younger entries (positions tag .. tail−1 modulo wrap).
  - `tail` ← tag; `count` ← (tag − head) mod NUM_CKPT.
  - Dispatch allocation and head retire are suppressed that cycle.
  - A mispredict on an invalid tag produces no rollback and no state change.
- Count update: `count` ← count + allocated − retired, or the mispredict value above.
- `head == tail` is disambiguated by `count`: 0 means empty, NUM_CKPT means full.

## Timing
- Reset (synchronous): head = tail = 0, count = 0, all entries invalid.
  - Outputs after reset: `ckpt_ready` = 1, `br_tag` = {1,0} when both slots are branches, `rollback_en` = 0, `FL_rollback_idx` = 0, `ckpt_count` = 0.
- Reset has priority over every input, including a mispredict in the same cycle.
- `ckpt_ready`, `br_tag`, `rollback_en` and `FL_rollback_idx` are combinational from state and inputs, with zero latency.
- `ckpt_count` is registered and updates one edge after the event.
- Same-cycle resolve and allocation of the same tag cannot occur, because an unallocated tag is invalid.
- When `rollback_en` = 0, `FL_rollback_idx` = 0.

## Test plan
- Reset, then dispatch with `br_dispatch=2'b11` and FL_idx={7,6}: br_tag={1,0}; next cycle ckpt_count=2, entry0.fl_idx=6, entry1.fl_idx=7.
- Fill all 4 entries: ckpt_ready=0 for br_dispatch=2'b01. A further dispatch_en leaves count=4 and tail unchanged.
- With tags 0–3 live, correct-resolve tag 2 and then tag 0: head retires tag 0 only. Resolve tag 1: tags 1 and 2 retire on successive cycles, and count goes 4→3→2→1.
- With head=2 and tail=1 (wrapped, count=3), mispredict tag 3, where entry3.fl_idx=19: in the same cycle rollback_en=1 and FL_rollback_idx=19. Next cycle tail=3, count=1, entries 3 and 0 are invalid.
- Mispredict together with dispatch of 2 branches and a retirable head: no allocation, no retire, rollback asserted; count equals (tag−head) mod 4.
- Resolve or mispredict on an invalid tag: rollback_en=0 and no state change. Reset asserted during a mispredict clears all state, and ckpt_count=0 after the edge.

Source files
------------

// File: rtl/fl_checkpoint_buf.sv
// fl_checkpoint_buf
// Branch checkpoint buffer for the free list's rollback port. Each dispatched branch records the
// free-list tail index that follows it and gets a tag. A correct resolve frees the checkpoint
// (retired in order from head); a mispredict drives the saved tail back to the free list and
// squashes the resolving checkpoint plus everything younger.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   dispatch_en         dispatch group accepted this cycle
//   br_dispatch[1:0]    slot i of the group is a branch
//   FL_idx[1:0]         free-list tail after slot i's allocation
//   br_resolve_en       branch unit resolves a branch this cycle
//   br_resolve_tag      tag of the resolving branch
//   br_mispredict       resolving branch was mispredicted
//   ckpt_ready          enough free entries for every branch in br_dispatch
//   br_tag[1:0]         tag assigned to slot i (always driven)
//   rollback_en         restore the free-list tail this cycle
//   FL_rollback_idx     tail value to restore (0 when rollback_en is low)
//   ckpt_count          number of live checkpoints (registered)
module fl_checkpoint_buf #(
  parameter int unsigned NUM_CKPT = 4,
  parameter int unsigned FL_IDX_W = 5,
  parameter int unsigned TAG_W    = $clog2(NUM_CKPT)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     dispatch_en,
  input  logic [1:0]               br_dispatch,
  input  logic [1:0][FL_IDX_W-1:0] FL_idx,
  input  logic                     br_resolve_en,
  input  logic [TAG_W-1:0]         br_resolve_tag,
  input  logic                     br_mispredict,
  output logic                     ckpt_ready,
  output logic [1:0][TAG_W-1:0]    br_tag,
  output logic                     rollback_en,
  output logic [FL_IDX_W-1:0]      FL_rollback_idx,
  output logic [TAG_W:0]           ckpt_count
);

  // Entry storage
  logic [NUM_CKPT-1:0] valid_q, valid_d;
  logic [NUM_CKPT-1:0] resolved_q, resolved_d;
  logic [FL_IDX_W-1:0] fl_idx_q [NUM_CKPT];
  logic [FL_IDX_W-1:0] fl_idx_d [NUM_CKPT];

  // Ring pointers; head == tail is disambiguated by count
  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;

  logic [1:0]       nbr;
  logic [TAG_W:0]   free_cnt;
  logic             mispredict_fire;
  logic             resolve_fire;
  logic             alloc;
  logic             retire;
  logic [TAG_W-1:0] keep_len;

  assign nbr      = {1'b0, br_dispatch[0]} + {1'b0, br_dispatch[1]};
  assign free_cnt = (TAG_W+1)'(NUM_CKPT) - count_q;

  assign ckpt_ready = (free_cnt >= (TAG_W+1)'(nbr));

  // Slot 1 takes the entry after slot 0 only if slot 0 is itself a branch
  assign br_tag[0] = tail_q;
  assign br_tag[1] = tail_q + TAG_W'(br_dispatch[0]);

  assign mispredict_fire = br_resolve_en & br_mispredict & valid_q[br_resolve_tag];
  assign resolve_fire    = br_resolve_en & ~br_mispredict & valid_q[br_resolve_tag];

  assign rollback_en     = mispredict_fire;
  assign FL_rollback_idx = mispredict_fire ? fl_idx_q[br_resolve_tag] : '0;

  assign alloc  = dispatch_en & ckpt_ready & ~mispredict_fire;
  // Uses registered resolved bit: an entry resolved this cycle retires next cycle at the earliest
  assign retire = valid_q[head_q] & resolved_q[head_q] & ~mispredict_fire;

  // Number of entries older than the mispredicted tag; they survive the squash
  assign keep_len = br_resolve_tag - head_q;

  always_comb begin
    valid_d    = valid_q;
    resolved_d = resolved_q;
    fl_idx_d   = fl_idx_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;

    if (mispredict_fire) begin
      // Squash by age relative to head, so a full ring (head == tail) is handled correctly
      for (int unsigned i = 0; i < NUM_CKPT; i++) begin
        if ((TAG_W'(i) - head_q) >= keep_len) begin
          valid_d[i]    = 1'b0;
          resolved_d[i] = 1'b0;
        end
      end
      tail_d  = br_resolve_tag;
      count_d = {1'b0, keep_len};
    end else begin
      if (resolve_fire) begin
        resolved_d[br_resolve_tag] = 1'b1;
      end

      if (retire) begin
        valid_d[head_q]    = 1'b0;
        resolved_d[head_q] = 1'b0;
        head_d             = head_q + TAG_W'(1);
      end

      // Allocated entries are invalid beforehand, so they never collide with resolve or retire
      if (alloc) begin
        for (int unsigned s = 0; s < 2; s++) begin
          if (br_dispatch[s]) begin
            valid_d[br_tag[s]]    = 1'b1;
            resolved_d[br_tag[s]] = 1'b0;
            fl_idx_d[br_tag[s]]   = FL_idx[s];
          end
        end
        tail_d = tail_q + TAG_W'(nbr);
      end

      count_d = count_q + (TAG_W+1)'(alloc ? nbr : 2'd0) - (TAG_W+1)'(retire);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q    <= '0;
      resolved_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      for (int unsigned i = 0; i < NUM_CKPT; i++) begin
        fl_idx_q[i] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      resolved_q <= resolved_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      for (int unsigned i = 0; i < NUM_CKPT; i++) begin
        fl_idx_q[i] <= fl_idx_d[i];
      end
    end
  end

  assign ckpt_count = count_q;

endmodule

// File: tb/tb_fl_checkpoint_buf.sv
// Testbench for fl_checkpoint_buf: directed steps push expected outputs into a scoreboard queue;
// a monitor on the falling edge pops and compares against the DUT.
module tb_fl_checkpoint_buf;

  logic            clock;
  logic            reset;
  logic            dispatch_en;
  logic [1:0]      br_dispatch;
  logic [1:0][4:0] FL_idx;
  logic            br_resolve_en;
  logic [1:0]      br_resolve_tag;
  logic            br_mispredict;
  logic            ckpt_ready;
  logic [1:0][1:0] br_tag;
  logic            rollback_en;
  logic [4:0]      FL_rollback_idx;
  logic [2:0]      ckpt_count;

  fl_checkpoint_buf #(
    .NUM_CKPT (4),
    .FL_IDX_W (5),
    .TAG_W    (2)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .dispatch_en     (dispatch_en),
    .br_dispatch     (br_dispatch),
    .FL_idx          (FL_idx),
    .br_resolve_en   (br_resolve_en),
    .br_resolve_tag  (br_resolve_tag),
    .br_mispredict   (br_mispredict),
    .ckpt_ready      (ckpt_ready),
    .br_tag          (br_tag),
    .rollback_en     (rollback_en),
    .FL_rollback_idx (FL_rollback_idx),
    .ckpt_count      (ckpt_count)
  );

  typedef struct {
    string      name;
    logic       ready;
    logic [1:0] tag1;
    logic [1:0] tag0;
    logic       rb;
    logic [4:0] idx;
    logic [2:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void chk(string name, string field, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d expected %0d", name, field, act, exp);
    end
  endfunction

  // Monitor: outputs are sampled mid-cycle, away from the rising edge
  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk(mon_e.name, "ckpt_ready", 32'(ckpt_ready), 32'(mon_e.ready));
      chk(mon_e.name, "br_tag1", 32'(br_tag[1]), 32'(mon_e.tag1));
      chk(mon_e.name, "br_tag0", 32'(br_tag[0]), 32'(mon_e.tag0));
      chk(mon_e.name, "rollback_en", 32'(rollback_en), 32'(mon_e.rb));
      chk(mon_e.name, "FL_rollback_idx", 32'(FL_rollback_idx), 32'(mon_e.idx));
      chk(mon_e.name, "ckpt_count", 32'(ckpt_count), 32'(mon_e.cnt));
    end
  end

  task automatic step(input string name, input logic rst, input logic de, input logic [1:0] brd,
                      input logic [4:0] fl1, input logic [4:0] fl0, input logic re,
                      input logic [1:0] rtag, input logic mp, input logic e_ready,
                      input logic [1:0] e_t1, input logic [1:0] e_t0, input logic e_rb,
                      input logic [4:0] e_idx, input logic [2:0] e_cnt);
    exp_t e;
    reset          = rst;
    dispatch_en    = de;
    br_dispatch    = brd;
    FL_idx[1]      = fl1;
    FL_idx[0]      = fl0;
    br_resolve_en  = re;
    br_resolve_tag = rtag;
    br_mispredict  = mp;
    e.name  = name;
    e.ready = e_ready;
    e.tag1  = e_t1;
    e.tag0  = e_t0;
    e.rb    = e_rb;
    e.idx   = e_idx;
    e.cnt   = e_cnt;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    dispatch_en    = 1'b0;
    br_dispatch    = 2'b00;
    FL_idx         = '0;
    br_resolve_en  = 1'b0;
    br_resolve_tag = 2'd0;
    br_mispredict  = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    //    name                rst de brd    fl1 fl0 re tag mp | rdy t1 t0 rb idx cnt
    step("reset_idle",        0, 0, 2'b11,  0,  0, 0, 0, 0,    1, 1, 0, 0,  0, 0);
    step("dispatch2",         0, 1, 2'b11,  7,  6, 0, 0, 0,    1, 1, 0, 0,  0, 0);
    step("fill",              0, 1, 2'b11, 19, 12, 0, 0, 0,    1, 3, 2, 0,  0, 2);
    step("full_blocked",      0, 1, 2'b01,  0,  5, 0, 0, 0,    0, 1, 0, 0,  0, 4);
    step("full_nobr",         0, 0, 2'b00,  0,  0, 0, 0, 0,    1, 0, 0, 0,  0, 4);
    step("resolve2",          0, 0, 2'b00,  0,  0, 1, 2, 0,    1, 0, 0, 0,  0, 4);
    step("resolve0",          0, 0, 2'b00,  0,  0, 1, 0, 0,    1, 0, 0, 0,  0, 4);
    step("retire0_resolve1",  0, 0, 2'b00,  0,  0, 1, 1, 0,    1, 0, 0, 0,  0, 4);
    step("retire1",           0, 0, 2'b00,  0,  0, 0, 0, 0,    1, 0, 0, 0,  0, 3);
    step("retire2",           0, 0, 2'b00,  0,  0, 0, 0, 0,    1, 0, 0, 0,  0, 2);
    // h=3 t=0: dispatch two more so the ring wraps (h=3, t=2, count=3)
    step("dispatch_wrap",     0, 1, 2'b11, 23, 21, 0, 0, 0,    1, 1, 0, 0,  0, 1);
    step("mispredict_mid",    0, 0, 2'b00,  0,  0, 1, 0, 1,    1, 2, 2, 1, 21, 3);
    // Mispredict on invalid tag 1: no rollback, no state change
    step("mp_invalid_tag",    0, 0, 2'b11,  0,  0, 1, 1, 1,    1, 1, 0, 0,  0, 1);
    step("dispatch_one",      0, 1, 2'b01,  0, 25, 0, 0, 0,    1, 1, 0, 0,  0, 1);
    step("resolve3",          0, 0, 2'b00,  0,  0, 1, 3, 0,    1, 1, 1, 0,  0, 2);
    // Mispredict tag 0 with 2-branch dispatch and retirable head 3: no alloc, no retire
    step("mp_with_dispatch",  0, 1, 2'b11, 30, 31, 1, 0, 1,    1, 2, 1, 1, 25, 2);
    step("after_mp2",         0, 0, 2'b11,  0,  0, 0, 0, 0,    1, 1, 0, 0,  0, 1);
    step("retire_late",       0, 0, 2'b00,  0,  0, 0, 0, 0,    1, 0, 0, 0,  0, 0);
    step("mp_empty",          0, 0, 2'b00,  0,  0, 1, 2, 1,    1, 0, 0, 0,  0, 0);
    step("resolve_empty",     0, 0, 2'b00,  0,  0, 1, 0, 0,    1, 0, 0, 0,  0, 0);
    step("dispatch17",        0, 1, 2'b01,  0, 17, 0, 0, 0,    1, 1, 0, 0,  0, 0);
    step("reset_during_mp",   1, 0, 2'b00,  0,  0, 1, 0, 1,    1, 1, 1, 1, 17, 1);
    step("post_reset",        0, 0, 2'b11,  0,  0, 0, 0, 0,    1, 1, 0, 0,  0, 0);
    step("post_reset_mp",     0, 0, 2'b11,  0,  0, 1, 0, 1,    1, 1, 0, 0,  0, 0);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
